// File: rtl/note_conv_sched.sv
// ============================================================================
// Module   : note_conv_sched
// Purpose  : Round-robin scheduler sharing one note2cnt converter among voices.
//            Optional cache (NOTE_SCHED_CACHE_EN) skips repeat conversions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_conv_sched #(
  parameter int VOICES   = 4,
  parameter int BW       = 16,
  parameter int CONV_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [VOICES-1:0]    req_i,
  input  logic [8*VOICES-1:0]  note_i,
  output logic [VOICES-1:0]    ack_o,
  output logic [BW*VOICES-1:0] period_o,
  output logic [7:0]           convNote_o,
  input  logic [BW-1:0]        convCnt_i,
  output logic                 busy_o
);

  localparam int VW = $clog2(VOICES);
  localparam int CW = $clog2(CONV_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [VW-1:0]   r_rr, r_grant, w_gnt, w_idx, w_rr_nxt;
  logic [CW-1:0]   r_cnt;
  logic [VOICES-1:0] r_ack, w_elig;
  logic [7:0]      r_conv_note;
  logic [7:0]      w_note [VOICES];
  logic [BW-1:0]   r_per  [VOICES];
  logic            w_any, w_hit, w_skip;
  int              w_sum;

  generate
    for (genvar v = 0; v < VOICES; v++) begin : g_voice
      assign w_note[v]            = note_i[8*v +: 8];
      assign period_o[BW*v +: BW] = r_per[v];
    end
  endgenerate

  // A voice acked this cycle is masked so a held request cannot win back-to-back.
  assign w_elig = req_i & ~r_ack;

  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = 0;
    w_idx = '0;
    // Scan from farthest to nearest so the closest eligible voice to r_rr wins.
    for (int i = VOICES - 1; i >= 0; i--) begin
      w_sum = int'(r_rr) + i;
      if (w_sum >= VOICES) w_sum = w_sum - VOICES;
      w_idx = VW'(w_sum);
      if (w_elig[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_rr_nxt = (r_grant == VW'(VOICES - 1)) ? '0 : r_grant + VW'(1);

`ifdef NOTE_SCHED_CACHE_EN
  logic [7:0]        r_last [VOICES];
  logic [VOICES-1:0] r_valid;
  logic              r_hit;

  assign w_hit  = r_valid[w_gnt] && (w_note[w_gnt] == r_last[w_gnt]);
  assign w_skip = r_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_hit   <= 1'b0;
      for (int v = 0; v < VOICES; v++) r_last[v] <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) r_hit <= w_hit;
      if (r_state == S_WRITE && !r_hit) begin
        r_last[r_grant]  <= r_conv_note;
        r_valid[r_grant] <= 1'b1;
      end
    end
  end
`else
  assign w_hit  = 1'b0;
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = w_hit ? S_WRITE : S_WAIT;
      S_WAIT:  if (r_cnt == CW'(1)) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack       <= '0;
      r_conv_note <= '0;
      r_cnt       <= '0;
      r_rr        <= '0;
      r_grant     <= '0;
      for (int v = 0; v < VOICES; v++) r_per[v] <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_gnt;
            if (!w_hit) begin
              r_conv_note <= w_note[w_gnt];
              r_cnt       <= CW'(CONV_LAT);
            end
          end
        end
        S_WAIT: r_cnt <= r_cnt - CW'(1);
        S_WRITE: begin
          if (!w_skip) r_per[r_grant] <= convCnt_i;
          r_ack <= VOICES'(1) << r_grant;
          r_rr  <= w_rr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign ack_o      = r_ack;
  assign convNote_o = r_conv_note;
  assign busy_o     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_note_conv_sched.sv
// Testbench for note_conv_sched with a behavioural one-cycle note2cnt converter.
`default_nettype none

module tb_note_conv_sched;
  localparam int VOICES = 4;
  localparam int BW     = 16;
`ifdef NOTE_SCHED_CACHE_EN
  localparam int HIT_LAT = 2;
`else
  localparam int HIT_LAT = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [VOICES-1:0]    req;
  logic [8*VOICES-1:0]  note;
  logic [VOICES-1:0]    ack;
  logic [BW*VOICES-1:0] period;
  logic [7:0]           conv_note;
  logic [BW-1:0]        conv_cnt = '0;
  logic                 busy;

  note_conv_sched #(.VOICES(VOICES), .BW(BW), .CONV_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .note_i(note), .ack_o(ack),
    .period_o(period), .convNote_o(conv_note), .convCnt_i(conv_cnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Stand-in converter: octaves halve the count, semitones step it down linearly.
  function automatic logic [15:0] conv_f(input logic [7:0] n);
    int d, base;
    if (n < 8'd21) return 16'd63488;
    d    = int'(n) - 21;
    base = 63488 - 2600 * (d % 12);
    return 16'(base >>> (d / 12));
  endfunction

  always @(posedge clk) conv_cnt <= conv_f(conv_note);

  int errors = 0, checks = 0;
  logic [15:0] exp_per [VOICES];
  int av [8], at [8], nack;

  typedef struct {
    int         voice;
    logic [7:0] nt;
    logic [15:0] per;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < VOICES; u++) exp_per[u] = '0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == '0 && lat < 30);
  endtask

  // Records voice and cycle of the next n acks, dropping requests listed in drop.
  task automatic collect(input int n, input logic [VOICES-1:0] drop);
    int t;
    t    = 0;
    nack = 0;
    for (int i = 0; i < 8; i++) begin av[i] = -1; at[i] = 0; end
    while (nack < n && t < 60) begin
      @(negedge clk);
      t++;
      if (ack != '0) begin
        for (int u = VOICES - 1; u >= 0; u--) if (ack[u]) av[nack] = u;
        at[nack] = t;
        if (drop[av[nack]]) req[av[nack]] = 1'b0;
        nack++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, v;
    tbl[0] = '{0, 8'd69,  16'd3968};
    tbl[1] = '{1, 8'd21,  16'd63488};
    tbl[2] = '{2, 8'd33,  16'd31744};
    tbl[3] = '{3, 8'd0,   16'd63488};
    tbl[4] = '{1, 8'd45,  16'd15872};
    tbl[5] = '{2, 8'd22,  16'd60888};
    tbl[6] = '{0, 8'd81,  16'd1984};
    tbl[7] = '{3, 8'd20,  16'd63488};

    note = '0;
    do_reset();
    chk("reset_ack", ack, 0);
    chk("reset_busy", busy, 0);
    chk("reset_conv_note", conv_note, 0);
    chk("reset_period", period, 0);

    // Single-voice transactions: latency, ack, note, and isolation of other voices.
    for (int i = 0; i < 8; i++) begin
      v = tbl[i].voice;
      note[8*v +: 8] = tbl[i].nt;
      req[v] = 1'b1;
      wait_ack(lat);
      req[v] = 1'b0;
      exp_per[v] = tbl[i].per;
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_ack", i), ack, 64'(1) << v);
      chk($sformatf("vec%0d_conv_note", i), conv_note, tbl[i].nt);
      for (int u = 0; u < VOICES; u++)
        chk($sformatf("vec%0d_period_v%0d", i, u), period[BW*u +: BW], exp_per[u]);
      @(negedge clk);
    end

    // All four voices at once: round-robin order, 3 cycles apart.
    do_reset();
    note = {8'd0, 8'd69, 8'd33, 8'd21};
    req  = 4'hF;
    collect(4, 4'hF);
    chk("rr_count", nack, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), av[i], i);
    for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), at[i] - at[i-1], 3);
    chk("rr_period_v0", period[15:0],  16'd63488);
    chk("rr_period_v1", period[31:16], 16'd31744);
    chk("rr_period_v2", period[47:32], 16'd3968);
    chk("rr_period_v3", period[63:48], 16'd63488);
    req = '0;
    @(negedge clk);

    // Voice 2 held, voice 0 pulsed: grants 2,0,2,2 and no back-to-back re-grant.
    do_reset();
    note = {8'd0, 8'd45, 8'd0, 8'd57};
    req[2] = 1'b1;
    @(negedge clk);
    req[0] = 1'b1;
    collect(4, 4'b0001);
    req = '0;
    chk("held_order0", av[0], 2);
    chk("held_order1", av[1], 0);
    chk("held_order2", av[2], 2);
    chk("held_order3", av[3], 2);
    chk("held_gap1", at[1] - at[0], 3);
    chk("held_gap2", at[2] - at[1], HIT_LAT);
    chk("held_gap3", at[3] - at[2], HIT_LAT + 1);
    chk("held_period_v0", period[15:0], 16'd7936);
    repeat (4) @(negedge clk);

    // Reset during WAIT aborts the conversion and rewinds the RR pointer.
    do_reset();
    note = {8'd0, 8'd33, 8'd69, 8'd0};
    req[1] = 1'b1;
    wait_ack(lat);
    req[1] = 1'b0;
    chk("abort_pre_period_v1", period[31:16], 16'd3968);
    @(negedge clk);
    req[2] = 1'b1;
    @(negedge clk);
    chk("abort_busy_in_wait", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    chk("abort_period", period, 0);
    chk("abort_conv_note", conv_note, 0);
    req = 4'hF;
    collect(1, 4'hF);
    req = '0;
    chk("abort_first_grant", av[0], 0);
    @(negedge clk);

    // Request dropped right after grant still completes.
    do_reset();
    note[15:8] = 8'd33;
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    wait_ack(lat);
    chk("early_drop_lat", lat, 2);
    chk("early_drop_ack", ack, 4'b0010);
    chk("early_drop_period", period[31:16], 16'd31744);

    // Repeat note on voice 1: cache hit shortens latency when enabled.
    do_reset();
    note[15:8] = 8'd33;
    req[1] = 1'b1;
    wait_ack(lat);
    req[1] = 1'b0;
    chk("repeat_first_lat", lat, 3);
    repeat (2) @(negedge clk);
    req[1] = 1'b1;
    @(negedge clk);
    chk("repeat_conv_note", conv_note, 8'd33);
    wait_ack(lat);
    req[1] = 1'b0;
    chk("repeat_lat", lat + 1, HIT_LAT);
    chk("repeat_ack", ack, 4'b0010);
    chk("repeat_period", period[31:16], 16'd31744);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
